// File: rtl/ssp_serdes.sv
// ---------------------------------------------------------------------------
// ssp_serdes
//   Full-duplex synchronous serial port running entirely on PCLK. Generates
//   SSPCLKOUT by division, shifts TX words out MSB first with a one-period
//   frame-sync pulse ahead of each word (back-to-back frames allowed), and
//   oversamples SSPCLKIN/SSPFSSIN/SSPRXD through 2-flop synchronisers to
//   assemble RX words, flagging overrun when a word lands on an unread one.
//
//   Optional feature: define SSP_LOOPBACK_EN to add the `loopback` input,
//   which routes the TX pins into the receiver and forces SSPOE_B high.
//
// Parameters
//   DATA_W   bits per frame (4..16)
//   CLK_DIV  PCLK cycles per SSPCLKOUT half-period (>=1)
//
// Ports
//   PCLK, CLEAR          clock; synchronous active-high reset
//   loopback             (SSP_LOOPBACK_EN only) internal TX->RX loop
//   tx_ready, TxData     TX FIFO word available / word to send
//   tx_load              pulse: TxData latched, FIFO pops
//   transmit_complete    pulse: LSB period of a frame finished
//   RxData, rx_ready     last received word / unread-word flag
//   rx_read              consumer read strobe, clears rx_ready
//   rx_overrun           sticky: word completed while rx_ready was set
//   SSPCLKIN/FSSIN/RXD   asynchronous serial inputs
//   SSPCLKOUT/FSSOUT/TXD serial outputs; SSPOE_B active-low TXD enable
// ---------------------------------------------------------------------------
module ssp_serdes #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2
) (
    input  logic              PCLK,
    input  logic              CLEAR,
`ifdef SSP_LOOPBACK_EN
    input  logic              loopback,
`endif
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] TxData,
    output logic              tx_load,
    output logic              transmit_complete,
    output logic [DATA_W-1:0] RxData,
    output logic              rx_ready,
    input  logic              rx_read,
    output logic              rx_overrun,
    input  logic              SSPCLKIN,
    input  logic              SSPFSSIN,
    input  logic              SSPRXD,
    output logic              SSPCLKOUT,
    output logic              SSPFSSOUT,
    output logic              SSPTXD,
    output logic              SSPOE_B
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] DIV_MAX  = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_SYNC, TX_DATA} tx_state_e;
    typedef enum logic       {RX_IDLE, RX_DATA}          rx_state_e;

    // Clock generator
    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic             sclk_q, sclk_d;
    logic             div_wrap, fall_tick;

    // Transmitter
    tx_state_e         tx_state_q, tx_state_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [BIT_W-1:0]  tx_bit_q, tx_bit_d;
    logic              fss_q, fss_d;
    logic              txd_q, txd_d;
    logic              oe_b_q, oe_b_d;
    logic              tx_load_c, tx_done_c;

    // Receiver
    logic              clk_src, fss_src, rxd_src;
    logic              clk_s1_q, clk_s2_q, clk_s3_q;
    logic              fss_s1_q, fss_s2_q;
    logic              rxd_s1_q, rxd_s2_q;
    logic              rx_rise;
    rx_state_e         rx_state_q, rx_state_d;
    logic [DATA_W-2:0] rx_sh_q, rx_sh_d;
    logic [BIT_W-1:0]  rx_bit_q, rx_bit_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_ready_q, rx_ready_d;
    logic              rx_ovr_q, rx_ovr_d;
    logic              rx_done_c;

    assign div_wrap  = (div_cnt_q == DIV_MAX);
    assign fall_tick = div_wrap & sclk_q;

`ifdef SSP_LOOPBACK_EN
    assign clk_src = loopback ? sclk_q : SSPCLKIN;
    assign fss_src = loopback ? fss_q  : SSPFSSIN;
    assign rxd_src = loopback ? txd_q  : SSPRXD;
    assign SSPOE_B = oe_b_q | loopback;
`else
    assign clk_src = SSPCLKIN;
    assign fss_src = SSPFSSIN;
    assign rxd_src = SSPRXD;
    assign SSPOE_B = oe_b_q;
`endif

    // clk_s3 is the previous synchronised level, used only for edge detect
    assign rx_rise = clk_s2_q & ~clk_s3_q;

    always_comb begin
        div_cnt_d = div_cnt_q + CNT_W'(1);
        sclk_d    = sclk_q;
        if (div_wrap) begin
            div_cnt_d = '0;
            sclk_d    = ~sclk_q;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_sh_d    = tx_sh_q;
        tx_bit_d   = tx_bit_q;
        fss_d      = fss_q;
        txd_d      = txd_q;
        oe_b_d     = oe_b_q;
        tx_load_c  = 1'b0;
        tx_done_c  = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (fall_tick && tx_ready) begin
                    tx_load_c  = 1'b1;
                    tx_sh_d    = TxData;
                    fss_d      = 1'b1;
                    tx_state_d = TX_SYNC;
                end
            end
            TX_SYNC: begin
                if (fall_tick) begin
                    fss_d      = 1'b0;
                    oe_b_d     = 1'b0;
                    txd_d      = tx_sh_q[DATA_W-1];
                    tx_sh_d    = {tx_sh_q[DATA_W-2:0], 1'b0};
                    tx_bit_d   = BIT_LAST;
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (fall_tick) begin
                    if (tx_bit_q != '0) begin
                        txd_d    = tx_sh_q[DATA_W-1];
                        tx_sh_d  = {tx_sh_q[DATA_W-2:0], 1'b0};
                        tx_bit_d = tx_bit_q - BIT_W'(1);
                    end else begin
                        // LSB period over; chain straight into the next
                        // frame's sync period when another word is waiting
                        tx_done_c = 1'b1;
                        oe_b_d    = 1'b1;
                        txd_d     = 1'b0;
                        if (tx_ready) begin
                            tx_load_c  = 1'b1;
                            tx_sh_d    = TxData;
                            fss_d      = 1'b1;
                            tx_state_d = TX_SYNC;
                        end else begin
                            tx_state_d = TX_IDLE;
                        end
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_sh_d    = rx_sh_q;
        rx_bit_d   = rx_bit_q;
        rx_data_d  = rx_data_q;
        rx_ready_d = rx_ready_q;
        rx_ovr_d   = rx_ovr_q;
        rx_done_c  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_rise && fss_s2_q) begin
                    rx_bit_d   = '0;
                    rx_state_d = RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_rise) begin
                    if (rx_bit_q == BIT_LAST) begin
                        rx_done_c  = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_sh_d  = {rx_sh_q[DATA_W-3:0], rxd_s2_q};
                        rx_bit_d = rx_bit_q + BIT_W'(1);
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase

        // A completing word wins over a read in the same cycle: the new
        // word is presented as unread, and that read is not an overrun.
        if (rx_done_c) begin
            rx_data_d  = {rx_sh_q, rxd_s2_q};
            rx_ready_d = 1'b1;
            if (rx_ready_q && !rx_read) begin
                rx_ovr_d = 1'b1;
            end
        end else if (rx_read) begin
            rx_ready_d = 1'b0;
        end
    end

    always_ff @(posedge PCLK) begin
        if (CLEAR) begin
            div_cnt_q  <= '0;
            sclk_q     <= 1'b0;
            tx_state_q <= TX_IDLE;
            tx_sh_q    <= '0;
            tx_bit_q   <= '0;
            fss_q      <= 1'b0;
            txd_q      <= 1'b0;
            oe_b_q     <= 1'b1;
            clk_s1_q   <= 1'b0;
            clk_s2_q   <= 1'b0;
            clk_s3_q   <= 1'b0;
            fss_s1_q   <= 1'b0;
            fss_s2_q   <= 1'b0;
            rxd_s1_q   <= 1'b0;
            rxd_s2_q   <= 1'b0;
            rx_state_q <= RX_IDLE;
            rx_sh_q    <= '0;
            rx_bit_q   <= '0;
            rx_data_q  <= '0;
            rx_ready_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            sclk_q     <= sclk_d;
            tx_state_q <= tx_state_d;
            tx_sh_q    <= tx_sh_d;
            tx_bit_q   <= tx_bit_d;
            fss_q      <= fss_d;
            txd_q      <= txd_d;
            oe_b_q     <= oe_b_d;
            clk_s1_q   <= clk_src;
            clk_s2_q   <= clk_s1_q;
            clk_s3_q   <= clk_s2_q;
            fss_s1_q   <= fss_src;
            fss_s2_q   <= fss_s1_q;
            rxd_s1_q   <= rxd_src;
            rxd_s2_q   <= rxd_s1_q;
            rx_state_q <= rx_state_d;
            rx_sh_q    <= rx_sh_d;
            rx_bit_q   <= rx_bit_d;
            rx_data_q  <= rx_data_d;
            rx_ready_q <= rx_ready_d;
            rx_ovr_q   <= rx_ovr_d;
        end
    end

    // Strobes are combinational on the fall tick; masked so a cycle spent
    // in CLEAR can never pop the FIFO or report a completed frame.
    assign tx_load           = tx_load_c & ~CLEAR;
    assign transmit_complete = tx_done_c & ~CLEAR;
    assign SSPCLKOUT         = sclk_q;
    assign SSPFSSOUT         = fss_q;
    assign SSPTXD            = txd_q;
    assign RxData            = rx_data_q;
    assign rx_ready          = rx_ready_q;
    assign rx_overrun        = rx_ovr_q;

endmodule

// File: tb/tb_ssp_serdes.sv
// ---------------------------------------------------------------------------
// tb_ssp_serdes
//   Directed/randomised bench for ssp_serdes. TX frames are judged from the
//   pins by counting cycles per frame and reassembling the word at mid-bit;
//   RX words are driven on the pins at an 8-PCLK serial clock and compared
//   with a small ready/overrun/data model kept here.
// ---------------------------------------------------------------------------
module tb_ssp_serdes;

`ifdef SSP_LOOPBACK_EN
    localparam int DW = 12;
    localparam int CD = 3;
`else
    localparam int DW = 8;
    localparam int CD = 2;
`endif
    localparam int FRAME  = 2 * CD * (DW + 1);
    localparam int OE_LOW = 2 * CD * DW;

    logic          PCLK = 1'b0;
    logic          CLEAR = 1'b1;
    logic          tx_ready = 1'b0;
    logic [DW-1:0] TxData = '0;
    logic          tx_load, transmit_complete;
    logic [DW-1:0] RxData;
    logic          rx_ready, rx_overrun;
    logic          rx_read = 1'b0;
    logic          SSPCLKIN = 1'b0, SSPFSSIN = 1'b0, SSPRXD = 1'b0;
    logic          SSPCLKOUT, SSPFSSOUT, SSPTXD, SSPOE_B;
`ifdef SSP_LOOPBACK_EN
    logic          loopback = 1'b0;
`endif

    ssp_serdes #(.DATA_W(DW), .CLK_DIV(CD)) dut (
        .PCLK              (PCLK),
        .CLEAR             (CLEAR),
`ifdef SSP_LOOPBACK_EN
        .loopback          (loopback),
`endif
        .tx_ready          (tx_ready),
        .TxData            (TxData),
        .tx_load           (tx_load),
        .transmit_complete (transmit_complete),
        .RxData            (RxData),
        .rx_ready          (rx_ready),
        .rx_read           (rx_read),
        .rx_overrun        (rx_overrun),
        .SSPCLKIN          (SSPCLKIN),
        .SSPFSSIN          (SSPFSSIN),
        .SSPRXD            (SSPRXD),
        .SSPCLKOUT         (SSPCLKOUT),
        .SSPFSSOUT         (SSPFSSOUT),
        .SSPTXD            (SSPTXD),
        .SSPOE_B           (SSPOE_B)
    );

    always #5 PCLK = ~PCLK;

    int            tests = 0;
    int            fails = 0;
    bit            ready_m = 1'b0;
    bit            ovr_m = 1'b0;
    logic [DW-1:0] data_m = '0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] out_vec();
        return {SSPCLKOUT, SSPFSSOUT, SSPTXD, SSPOE_B,
                tx_load, transmit_complete, rx_ready, rx_overrun};
    endfunction

    task automatic wait_load(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4 * CD + 4; i++) begin
            #1;
            if (tx_load === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge PCLK);
        end
    endtask

    // Entered in the cycle whose tx_load has just been seen; k counts PCLK
    // cycles after that one. Data bit m is sampled mid-period.
    task automatic tx_frame(input logic [DW-1:0] w, input bit chain,
                            input logic [DW-1:0] nxt, input int oe_exp);
        logic [DW-1:0] obs;
        int fss_n, oe_n, tc_n, tc_at, ld_n;
        logic ld_end;
        obs = '0; fss_n = 0; oe_n = 0; tc_n = 0; tc_at = -1; ld_n = 0; ld_end = 1'b0;
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge PCLK);
            if (SSPFSSOUT === 1'b1) fss_n++;
            if (SSPOE_B === 1'b0) oe_n++;
            if (transmit_complete === 1'b1) begin
                tc_n++;
                tc_at = k;
            end
            if (k < FRAME && tx_load !== 1'b0) ld_n++;
            if (k == FRAME) ld_end = tx_load;
            if (k > 2 * CD && ((k - 1 - 2 * CD) % (2 * CD)) == CD)
                obs = {obs[DW-2:0], SSPTXD};
            if (k == 1) begin
                TxData   = nxt;
                tx_ready = chain;
            end
        end
        check("tx_word", obs, w);
        check("tx_fss_cycles", fss_n, 2 * CD);
        check("tx_oe_low_cycles", oe_n, oe_exp);
        check("tx_complete_count", tc_n, 1);
        check("tx_complete_cycle", tc_at, FRAME);
        check("tx_load_midframe", ld_n, 0);
        check("tx_load_at_end", ld_end, chain);
    endtask

    task automatic tx_idle_check();
        @(negedge PCLK);
        check("tx_idle_pins", {SSPOE_B, SSPTXD, SSPFSSOUT}, 3'b100);
    endtask

    task automatic rx_word(input logic [DW-1:0] w, input bit read_at_done);
        SSPFSSIN = 1'b1;
        SSPCLKIN = 1'b0;
        repeat (4) @(negedge PCLK);
        SSPCLKIN = 1'b1;
        repeat (4) @(negedge PCLK);
        for (int i = DW - 1; i >= 0; i--) begin
            SSPCLKIN = 1'b0;
            SSPFSSIN = 1'($urandom);
            SSPRXD   = w[i];
            repeat (4) @(negedge PCLK);
            SSPCLKIN = 1'b1;
            if (i > 0) begin
                repeat (4) @(negedge PCLK);
            end else begin
                @(negedge PCLK);
                @(negedge PCLK);
                check("rx_ready_before_latency", rx_ready, ready_m);
                rx_read = read_at_done;
                @(negedge PCLK);
                rx_read = 1'b0;
                if (ready_m && !read_at_done) ovr_m = 1'b1;
                ready_m = 1'b1;
                data_m  = w;
                check("rx_ready_at_latency", rx_ready, ready_m);
                check("rx_data", RxData, data_m);
                check("rx_overrun", rx_overrun, ovr_m);
                @(negedge PCLK);
            end
        end
        SSPCLKIN = 1'b0;
        SSPFSSIN = 1'b0;
        SSPRXD   = 1'b0;
        repeat (4) @(negedge PCLK);
    endtask

    task automatic do_read();
        rx_read = 1'b1;
        @(negedge PCLK);
        rx_read = 1'b0;
        ready_m = 1'b0;
        check("rx_read_clears_ready", rx_ready, ready_m);
        check("rx_overrun_after_read", rx_overrun, ovr_m);
    endtask

    initial begin
        bit            ok;
        bit            seen;
        logic [DW-1:0] w0, w1, w2;

        repeat (3) @(negedge PCLK);
        check("reset_outputs", out_vec(), 8'b0001_0000);
        check("reset_rxdata", RxData, '0);
        CLEAR = 1'b0;

        // Single frame, directed word, then random single frames
        w0 = DW'('hA5);
        TxData = w0; tx_ready = 1'b1;
        wait_load(ok);
        check("tx_load_seen", ok, 1);
        tx_frame(w0, 1'b0, '0, OE_LOW);
        tx_idle_check();
        for (int n = 0; n < 2; n++) begin
            repeat ($urandom_range(0, 5)) @(negedge PCLK);
            w0 = DW'($urandom);
            TxData = w0; tx_ready = 1'b1;
            wait_load(ok);
            check("tx_load_seen", ok, 1);
            tx_frame(w0, 1'b0, '0, OE_LOW);
            tx_idle_check();
        end

        // Back-to-back frames with tx_ready held
        w0 = DW'('h3C); w1 = DW'('hC3); w2 = DW'($urandom);
        TxData = w0; tx_ready = 1'b1;
        wait_load(ok);
        check("tx_load_seen", ok, 1);
        tx_frame(w0, 1'b1, w1, OE_LOW);
        tx_frame(w1, 1'b1, w2, OE_LOW);
        tx_frame(w2, 1'b0, '0, OE_LOW);
        tx_idle_check();

        // Receive: directed then random words, each read back
        rx_word(DW'('h5A), 1'b0);
        do_read();
        for (int n = 0; n < 2; n++) begin
            rx_word(DW'($urandom), 1'b0);
            do_read();
        end

        // Read coinciding with completion: no overrun
        rx_word(DW'($urandom), 1'b0);
        rx_word(DW'($urandom), 1'b1);
        do_read();

        // Two words without a read: overrun, sticky across rx_read
        rx_word(DW'('h11), 1'b0);
        rx_word(DW'('h22), 1'b0);
        do_read();

`ifdef SSP_LOOPBACK_EN
        loopback = 1'b1;
        w0 = DW'($urandom);
        TxData = w0; tx_ready = 1'b1;
        wait_load(ok);
        check("tx_load_seen_lb", ok, 1);
        tx_frame(w0, 1'b0, '0, 0);
        repeat (6) @(negedge PCLK);
        if (ready_m) ovr_m = 1'b1;
        ready_m = 1'b1;
        data_m  = w0;
        check("lb_rx_ready", rx_ready, ready_m);
        check("lb_rx_data", RxData, data_m);
        check("lb_rx_overrun", rx_overrun, ovr_m);
        check("lb_oe_b", SSPOE_B, 1);
        do_read();
        loopback = 1'b0;
`endif

        // CLEAR in the middle of a TX frame and an RX word
        TxData = DW'($urandom); tx_ready = 1'b1;
        wait_load(ok);
        check("tx_load_seen_pre_clear", ok, 1);
        @(negedge PCLK);
        tx_ready = 1'b0;
        SSPFSSIN = 1'b1;
        repeat (4) @(negedge PCLK);
        SSPCLKIN = 1'b1;
        repeat (4) @(negedge PCLK);
        SSPFSSIN = 1'b0;
        for (int i = 0; i < 2; i++) begin
            SSPCLKIN = 1'b0; SSPRXD = 1'b1;
            repeat (4) @(negedge PCLK);
            SSPCLKIN = 1'b1;
            repeat (4) @(negedge PCLK);
        end
        CLEAR = 1'b1; SSPCLKIN = 1'b0; SSPRXD = 1'b0;
        seen = 1'b0;
        @(negedge PCLK);
        check("clear_outputs_first_cycle", out_vec(), 8'b0001_0000);
        repeat (2) @(negedge PCLK);
        check("clear_outputs", out_vec(), 8'b0001_0000);
        check("clear_rxdata", RxData, '0);
        CLEAR = 1'b0;
        ready_m = 1'b0; ovr_m = 1'b0; data_m = '0;
        for (int k = 0; k < FRAME; k++) begin
            @(negedge PCLK);
            if (transmit_complete !== 1'b0 || tx_load !== 1'b0) seen = 1'b1;
        end
        check("no_tx_activity_after_clear", seen, 0);
        check("rx_idle_after_clear", rx_ready, 0);
        rx_word(DW'($urandom), 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ssp_serdes.md
# ssp_serdes

Parametrised successor to the team's SSP transmit/receive logic: a full-duplex synchronous serial port with configurable word width and serial clock divider. It runs entirely on PCLK, generates SSPCLKOUT by division, oversamples the incoming SSPCLKIN/SSPFSSIN/SSPRXD through synchronisers, and supports back-to-back transmit frames plus receive overrun detection. It sits between the TX/RX FIFOs and the SSP pins.

## Interface
- DATA_W, 8: bits per frame, legal 4–16.
- CLK_DIV, 2: PCLK cycles per SSPCLKOUT half-period, legal ≥1.

- PCLK  in  1  sole clock.
- CLEAR  in  1  reset. Synchronous, active-high.
- tx_ready  in  1  TxData valid; TX FIFO has a word.
- TxData  in  DATA_W  word to send, MSB first.
- tx_load  out  1  one-PCLK pulse: TxData latched; FIFO pops.
- transmit_complete  out  1  one-PCLK pulse: frame's LSB period finished.
- RxData  out  DATA_W  last received word.
- rx_ready  out  1  level: RxData holds an unread word.
- rx_read  in  1  consumer read; clears rx_ready.
- rx_overrun  out  1  sticky: word completed while rx_ready set.
- SSPCLKIN, SSPFSSIN, SSPRXD  in  1 each  asynchronous serial inputs.
- SSPCLKOUT, SSPFSSOUT, SSPTXD  out  1 each  serial outputs.
- SSPOE_B  out  1  active-low TXD output enable.

## Operation
- Clock gen: counter 0..CLK_DIV-1, free-running. SSPCLKOUT toggles on wrap. "Fall tick" = PCLK cycle where SSPCLKOUT goes 1→0. All TX outputs change only on fall ticks.
- TX FSM IDLE/SYNC/DATA:
  - IDLE, fall tick, tx_ready=1: latch TxData, pulse tx_load, SSPFSSOUT=1, go to SYNC.
  - SYNC, next fall tick: SSPFSSOUT=0, SSPOE_B=0, SSPTXD=MSB, bit counter=DATA_W-1, go to DATA.
  - DATA, each fall tick: shift out the next bit.
  - Fall tick after the LSB period: pulse transmit_complete.
    - If tx_ready=1: same cycle, latch the new word, pulse tx_load, SSPFSSOUT=1, SSPOE_B=1, go to SYNC. No idle gap.
    - Else: SSPOE_B=1, SSPTXD=0, go to IDLE.
- RX:
  - All three inputs pass through identical 2-flop synchronisers.
  - Act on synced SSPCLKIN rising edges. The edge with SSPFSSIN=1 in idle arms the receiver.
  - The next DATA_W rising edges sample SSPRXD MSB first.
  - After the last bit: RxData updated, rx_ready=1, receiver idle.
  - SSPFSSIN during data bits is ignored.
- rx_read with rx_ready=1 clears rx_ready.
- Completion while rx_ready=1 and no rx_read: overwrite RxData, set rx_overrun (cleared only by CLEAR).
- Completion and rx_read in the same cycle: new word, rx_ready stays 1, no overrun.

## Timing
- Reset values: SSPCLKOUT=0, SSPFSSOUT=0, SSPTXD=0, SSPOE_B=1, tx_load=0, transmit_complete=0, RxData=0, rx_ready=0, rx_overrun=0. Divider, shift registers, counters and synchronisers are all 0; both FSMs idle.
- CLEAR mid-frame aborts immediately. No transmit_complete pulse, no partial RxData.
- TX frame length: 2·CLK_DIV·(DATA_W+1) PCLK cycles from tx_load to transmit_complete.
- tx_ready is sampled only on fall ticks in IDLE or at end of frame.
- RX latency: rx_ready rises 3 PCLK cycles after the pin-level SSPCLKIN rising edge carrying the LSB (2 sync + 1 register).
- RX input constraint: each SSPCLKIN level lasts ≥2 PCLK cycles. Faster input is undefined.

## Configuration
- SSP_LOOPBACK_EN defined:
  - Adds input port loopback (1 bit).
  - When loopback=1, the receiver's synchroniser inputs take SSPCLKOUT/SSPFSSOUT/SSPTXD instead of the pins, and SSPOE_B is forced to 1.
  - loopback must change only while both FSMs are idle.
- Undefined: no loopback port; the receiver always uses the pins.

## Test plan
- Reset: assert CLEAR 3 cycles mid-frame → all outputs at reset values next cycle, no transmit_complete pulse.
- TX single (DATA_W=8, CLK_DIV=2): TxData=8'hA5, tx_ready pulsed once → one-period FSS pulse, then SSPTXD 1,0,1,0,0,1,0,1 on successive fall ticks; transmit_complete 36 PCLK after tx_load; SSPOE_B low only during the data bits.
- TX back-to-back: 8'h3C then 8'hC3 with tx_ready held → second tx_load coincides with the first transmit_complete; no IDLE cycle.
- RX: SSPCLKIN period 8 PCLK, FSS edge then 8'h5A → RxData=8'h5A, rx_ready high 3 PCLK after the LSB rising edge; rx_read clears it.
- Overrun: receive 8'h11 then 8'h22 without rx_read → RxData=8'h22, rx_overrun=1, persisting after rx_read; same-cycle read+complete → no overrun.
- Loopback (SSP_LOOPBACK_EN, DATA_W=12, CLK_DIV=3): loopback=1, send 12'hABC → RxData=12'hABC, SSPOE_B stays 1.
